// File: rtl/ama_riscv_store_shift_mask.sv
// Store-path shift/mask unit: aligns rs2 data to the addressed byte lanes, builds the
// byte write mask, rejects illegal stores and buffers up to two writes toward memory.
module ama_riscv_store_shift_mask #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    output logic                 in_ready,
    input  logic [1:0]           offset,
    input  logic [1:0]           width,
    input  logic [31:0]          data_in,
    output logic                 req_valid,
    input  logic                 mem_ready,
    output logic [31:0]          req_data,
    output logic [3:0]           req_mask,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_e;

    function automatic logic store_legal(input logic [1:0] w, input logic [1:0] off);
        logic ok;
        case (w)
            2'd0:    ok = 1'b1;
            2'd1:    ok = (off != 2'd3);
            2'd2:    ok = (off == 2'd0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_mask(input logic [1:0] w, input logic [1:0] off);
        logic [3:0] m;
        case (w)
            2'd0:    m = 4'b0001 << off;
            2'd1:    m = 4'b0011 << off;
            2'd2:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Lanes outside the mask are zeroed so memory never sees leftover rs2 bytes.
    function automatic logic [31:0] store_data(input logic [31:0] d, input logic [1:0] off,
                                               input logic [3:0] m);
        logic [31:0] shifted;
        logic [31:0] res;
        shifted = d << {off, 3'b000};
        for (int k = 0; k < 4; k++) begin
            res[8*k +: 8] = shifted[8*k +: 8] & {8{m[k]}};
        end
        return res;
    endfunction

    occ_e                 state_r;
    occ_e                 state_next_s;
    logic [31:0]          out_data_r;
    logic [3:0]           out_mask_r;
    logic [31:0]          skid_data_r;
    logic [3:0]           skid_mask_r;
    logic                 err_r;
    logic [ERR_CNT_W-1:0] err_cnt_r;

    logic                 accept_s;
    logic                 legal_s;
    logic                 push_s;
    logic                 reject_s;
    logic                 xfer_s;
    logic                 load_out_in_s;
    logic                 load_out_skid_s;
    logic                 load_skid_s;
    logic [3:0]           new_mask_s;
    logic [31:0]          new_data_s;

    assign in_ready   = (state_r != ST_TWO);
    assign req_valid  = (state_r != ST_EMPTY);
    assign req_data   = out_data_r;
    assign req_mask   = out_mask_r;
    assign err        = err_r;
    assign err_cnt    = err_cnt_r;

    assign accept_s   = en && in_ready;
    assign legal_s    = store_legal(width, offset);
    assign push_s     = accept_s && legal_s;
    assign reject_s   = accept_s && !legal_s;
    assign xfer_s     = req_valid && mem_ready;
    assign new_mask_s = store_mask(width, offset);
    assign new_data_s = store_data(data_in, offset, new_mask_s);

    // Occupancy state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next occupancy and which entry each incoming/outgoing request lands in.
    always_comb begin
        state_next_s    = state_r;
        load_out_in_s   = 1'b0;
        load_out_skid_s = 1'b0;
        load_skid_s     = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (push_s) begin
                    state_next_s  = ST_ONE;
                    load_out_in_s = 1'b1;
                end else begin
                    state_next_s  = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (push_s && xfer_s) begin
                    state_next_s  = ST_ONE;
                    load_out_in_s = 1'b1;
                end else if (push_s) begin
                    state_next_s  = ST_TWO;
                    load_skid_s   = 1'b1;
                end else if (xfer_s) begin
                    state_next_s  = ST_EMPTY;
                end else begin
                    state_next_s  = ST_ONE;
                end
            end
            ST_TWO: begin
                if (xfer_s) begin
                    state_next_s    = ST_ONE;
                    load_out_skid_s = 1'b1;
                end else begin
                    state_next_s    = ST_TWO;
                end
            end
            default: begin
                state_next_s = ST_EMPTY;
            end
        endcase
    end

    // OUT entry: held stable while memory stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_r <= 32'h0000_0000;
            out_mask_r <= 4'b0000;
        end else if (load_out_in_s) begin
            out_data_r <= new_data_s;
            out_mask_r <= new_mask_s;
        end else if (load_out_skid_s) begin
            out_data_r <= skid_data_r;
            out_mask_r <= skid_mask_r;
        end else begin
            out_data_r <= out_data_r;
            out_mask_r <= out_mask_r;
        end
    end

    // SKID entry: validity is carried by the occupancy state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_data_r <= 32'h0000_0000;
            skid_mask_r <= 4'b0000;
        end else if (load_skid_s) begin
            skid_data_r <= new_data_s;
            skid_mask_r <= new_mask_s;
        end else begin
            skid_data_r <= skid_data_r;
            skid_mask_r <= skid_mask_r;
        end
    end

    // Error pulse and saturating reject counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r     <= 1'b0;
            err_cnt_r <= {ERR_CNT_W{1'b0}};
        end else begin
            err_r <= reject_s;
            if (reject_s && !(&err_cnt_r)) begin
                err_cnt_r <= err_cnt_r + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_ama_riscv_store_shift_mask.sv
// Scoreboard bench for ama_riscv_store_shift_mask: stimulus pushes expected writes,
// a negedge monitor pops them on every transfer and tracks err/err_cnt.
module tb_ama_riscv_store_shift_mask;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_ready;
    logic [1:0]  offset;
    logic [1:0]  width;
    logic [31:0] data_in;
    logic        req_valid;
    logic        mem_ready;
    logic [31:0] req_data;
    logic [3:0]  req_mask;
    logic        err;
    logic [7:0]  err_cnt;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  m;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    logic pend_ill = 1'b0;
    logic [7:0] cnt_m = 8'd0;

    ama_riscv_store_shift_mask #(.ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .in_ready(in_ready), .offset(offset),
        .width(width), .data_in(data_in), .req_valid(req_valid), .mem_ready(mem_ready),
        .req_data(req_data), .req_mask(req_mask), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_legal(input logic [1:0] w, input logic [1:0] o);
        return (w == 2'd0) || (w == 2'd1 && o != 2'd3) || (w == 2'd2 && o == 2'd0);
    endfunction

    // Reference: request byte b lands in lane offset+b for b < access size.
    function automatic exp_t m_expect(input logic [1:0] w, input logic [1:0] o,
                                      input logic [31:0] d);
        exp_t e;
        int   sz;
        int   oi;
        e  = '0;
        oi = int'(o);
        sz = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
        for (int k = 0; k < 4; k++) begin
            if (k >= oi && k < oi + sz) begin
                e.m[k]       = 1'b1;
                e.d[8*k +: 8] = d[8*(k-oi) +: 8];
            end
        end
        return e;
    endfunction

    // Monitor: err/err_cnt model plus scoreboard pop on each transfer.
    always @(negedge clk) begin
        if (rst) begin
            pend_ill = 1'b0;
            cnt_m    = 8'd0;
        end else begin
            if (pend_ill && cnt_m != 8'hFF) cnt_m = cnt_m + 8'd1;
            chk("err", 32'(err), 32'(pend_ill));
            chk("err_cnt", 32'(err_cnt), 32'(cnt_m));
            if (req_valid && mem_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_xfer", 32'(req_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("req_data", req_data, e.d);
                    chk("req_mask", 32'(req_mask), 32'(e.m));
                end
            end
            pend_ill = en && in_ready && !m_legal(width, offset);
        end
    end

    // Drive one request from posedge+1; returns at posedge+1 after acceptance.
    task automatic issue(input logic [1:0] w, input logic [1:0] o, input logic [31:0] d,
                         input bit use_x, input logic [31:0] xd, input logic [3:0] xm,
                         output int stalls);
        bit   got;
        exp_t e;
        en = 1'b1; width = w; offset = o; data_in = d;
        stalls = 0;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            stalls++;
        end
        if (!got) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1 en = 1'b0;
        end else begin
            @(posedge clk);
            if (m_legal(w, o)) begin
                if (use_x) begin
                    e.d = xd;
                    e.m = xm;
                end else begin
                    e = m_expect(w, o, d);
                end
                sb_q.push_back(e);
            end
            #1 en = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    int st;
    int st_sum;
    logic [1:0] rw;
    logic [1:0] ro;

    initial begin
        rst = 1'b1; en = 1'b0; offset = 2'd0; width = 2'd0;
        data_in = 32'h0; mem_ready = 1'b0;
        #2;
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_req_data", req_data, 32'h0);
        chk("rst_req_mask", 32'(req_mask), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        mem_ready = 1'b1;

        // Directed lane placement.
        issue(2'd0, 2'd3, 32'hA1B2C3D4, 1'b1, 32'hD4000000, 4'b1000, st);
        chk("sb_o3_valid", 32'(req_valid), 32'd1);
        issue(2'd0, 2'd0, 32'hA1B2C3D4, 1'b1, 32'h000000D4, 4'b0001, st);
        issue(2'd1, 2'd1, 32'h1234BEEF, 1'b1, 32'h00BEEF00, 4'b0110, st);
        issue(2'd1, 2'd2, 32'h1234BEEF, 1'b1, 32'hBEEF0000, 4'b1100, st);
        drain();

        // Illegal stores.
        issue(2'd2, 2'd2, 32'hDEADBEEF, 1'b0, 32'h0, 4'b0, st);
        chk("ill_sw_err", 32'(err), 32'd1);
        chk("ill_sw_cnt", 32'(err_cnt), 32'd1);
        chk("ill_no_valid", 32'(req_valid), 32'd0);
        @(posedge clk);
        #1 chk("ill_err_pulse_end", 32'(err), 32'd0);
        issue(2'd3, 2'd0, 32'h12345678, 1'b0, 32'h0, 4'b0, st);
        chk("ill_w3_cnt", 32'(err_cnt), 32'd2);
        issue(2'd1, 2'd3, 32'h12345678, 1'b0, 32'h0, 4'b0, st);
        chk("ill_sh3_cnt", 32'(err_cnt), 32'd3);
        for (int i = 0; i < 300; i++) begin
            case (i % 3)
                0:       issue(2'd3, 2'(i % 4), 32'(i), 1'b0, 32'h0, 4'b0, st);
                1:       issue(2'd2, 2'(1 + (i % 3)), 32'(i), 1'b0, 32'h0, 4'b0, st);
                default: issue(2'd1, 2'd3, 32'(i), 1'b0, 32'h0, 4'b0, st);
            endcase
        end
        chk("ill_sat_cnt", 32'(err_cnt), 32'd255);

        // Backpressure with ordered release.
        mem_ready = 1'b0;
        issue(2'd2, 2'd0, 32'h11111111, 1'b1, 32'h11111111, 4'b1111, st);
        chk("bp_ready_after1", 32'(in_ready), 32'd1);
        issue(2'd2, 2'd0, 32'h22222222, 1'b1, 32'h22222222, 4'b1111, st);
        chk("bp_ready_after2", 32'(in_ready), 32'd0);
        fork
            issue(2'd2, 2'd0, 32'h33333333, 1'b1, 32'h33333333, 4'b1111, st);
            begin
                repeat (3) @(posedge clk);
                #2;
                chk("bp_held", 32'(in_ready), 32'd0);
                chk("bp_out_stable", req_data, 32'h11111111);
                mem_ready = 1'b1;
                @(posedge clk);
                #1 chk("bp_ready_back", 32'(in_ready), 32'd1);
            end
        join
        drain();

        // Streaming random legal stores at full rate.
        st_sum = 0;
        for (int i = 0; i < 64; i++) begin
            rw = 2'($urandom_range(0, 2));
            ro = (rw == 2'd0) ? 2'($urandom_range(0, 3)) :
                 (rw == 2'd1) ? 2'($urandom_range(0, 2)) : 2'd0;
            issue(rw, ro, $urandom, 1'b0, 32'h0, 4'b0, st);
            st_sum += st;
        end
        chk("stream_stalls", 32'(st_sum), 32'd0);
        drain();

        // Asynchronous reset with two entries pending.
        mem_ready = 1'b0;
        issue(2'd2, 2'd0, 32'hAAAA5555, 1'b0, 32'h0, 4'b0, st);
        issue(2'd0, 2'd1, 32'h0F0F0F0F, 1'b0, 32'h0, 4'b0, st);
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("arst_req_valid", 32'(req_valid), 32'd0);
        chk("arst_req_data", req_data, 32'h0);
        chk("arst_req_mask", 32'(req_mask), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_err_cnt", 32'(err_cnt), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        sb_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        mem_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("post_rst_no_valid", 32'(req_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ama_riscv_store_shift_mask.md
# ama_riscv_store_shift_mask

Store-path counterpart of the load shift/mask unit, sitting between the MEM-stage store request and the data-memory write port. Inputs are the raw rs2 store data plus the address offset and store width. The block aligns the data to the addressed byte lanes and generates a 4-bit byte write mask. It rejects illegal or misaligned stores with an error pulse and a saturating count, and buffers up to two pending writes behind a valid/ready handshake to memory.

## Interface
Parameters:
- ERR_CNT_W, 8, width of saturating error counter

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  store request valid
- in_ready  out  1  block can accept a request this cycle
- offset  in  2  address bits [1:0]
- width  in  2  funct3[1:0]: 0 = byte, 1 = half, 2 = word, 3 = illegal
- data_in  in  32  unaligned store data (rs2)
- req_valid  out  1  write request to memory valid
- mem_ready  in  1  memory accepts request this cycle
- req_data  out  32  lane-aligned write data
- req_mask  out  4  byte write enables, bit k = byte lane k
- err  out  1  one-cycle pulse: rejected store
- err_cnt  out  ERR_CNT_W  saturating count of rejected stores

## Operation
- Accept = en && in_ready at posedge. If en && !in_ready, the request is ignored and produces no err; upstream holds it.
- Legal accesses:
  - byte: any offset; mask = 4'b0001 << offset.
  - half: offsets 0..2; mask = 4'b0011 << offset.
  - word: offset 0 only; mask = 4'b1111.
- Data: req_data = (data_in << 8*offset) with every byte lane whose mask bit is 0 forced to 8'h00.
- Illegal cases: width 3, half at offset 3, word at offset 1..3.
  - Not enqueued.
  - err = 1 for the cycle after accept.
  - err_cnt increments and saturates at all-ones.
- Storage: output register (OUT) plus one skid entry (SKID). The FIFO order of legal requests is preserved.
  - Transfer occurs when req_valid && mem_ready at posedge.
  - A legal accept goes to OUT if OUT is empty or transferring this cycle and SKID is empty; otherwise it goes to SKID.
  - On transfer with SKID full, SKID moves to OUT and SKID empties.
- in_ready = !SKID_valid, driven combinationally from the register.
- Occupancy states:
  - EMPTY (0): legal accept → ONE.
  - ONE: legal accept without transfer → TWO; transfer without accept → EMPTY; both → ONE.
  - TWO: in_ready = 0; transfer → ONE.

## Timing
- Reset values: req_valid 0, req_data 0, req_mask 0, err 0, err_cnt 0, in_ready 1, both entries invalid.
- Reset is asynchronous. Assertion mid-operation drops all pending requests immediately; no transfer completes after assertion.
- Latency: a legal accept at edge N gives req_valid = 1 after edge N when OUT was empty or transferring.
- req_data and req_mask are stable while req_valid && !mem_ready.
- err pulses after edge N for an illegal accept at edge N. Back-to-back illegal accepts hold err high continuously.
- Throughput: one request per cycle with mem_ready held high.
- Simultaneous accept and transfer in ONE: the new request goes straight to OUT and in_ready stays 1.
- mem_ready has no effect when req_valid = 0.

## Test plan
- Byte lanes: sb, offset 3, data 0xA1B2C3D4, mem_ready = 1 → next cycle req_valid = 1, req_mask = 4'b1000, req_data = 0xD4000000. Offset 0 → 4'b0001, 0x000000D4.
- Halfword: sh, offset 1, data 0x1234BEEF → req_mask = 4'b0110, req_data = 0x00BEEF00. Offset 2 → 4'b1100, 0xBEEF0000.
- Illegal:
  - sw at offset 2 → no req_valid, err pulses one cycle, err_cnt = 1.
  - Then width 3 → err_cnt = 2.
  - Then sh at offset 3 → err_cnt = 3.
  - 300 illegal accepts → err_cnt = 255.
- Backpressure: mem_ready = 0, three back-to-back sw with data 0x11111111, 0x22222222, 0x33333333.
  - in_ready drops after the 2nd; the 3rd is held by the bench.
  - Raise mem_ready → transfers occur in order 0x11111111, 0x22222222, 0x33333333, with in_ready returning to 1 after the first transfer.
- Streaming: 64 random legal stores with mem_ready = 1 → one transfer per cycle. Each transfer matches the scoreboard (mask/data per rules), err = 0.
- Reset mid-operation: two entries pending, mem_ready = 0, assert rst between edges → req_valid, req_mask, req_data, err, err_cnt go to 0 immediately and in_ready = 1. No stale transfer appears after release.
